// File: rtl/steering_controller.sv
// ---------------------------------------------------------------------------
// steering_controller
//
// Turns a per-frame line-centroid measurement into a rate-limited servo
// pulse width and generates the matching servo PWM waveform.
//
// A 3-stage pipeline runs once per accepted frame:
//   stage 1  clamp the centroid column and register the good/miss verdict
//   stage 2  steer_error = centroid - IMG_W/2, product = steer_error * GAIN
//   stage 3  state machine (TRACK / HOLD / SEARCH), target saturation and
//            per-frame step limiting, pulse_width rewrite + update_pulse
// frame_end pulses that arrive while stage 1 or stage 2 is occupied are
// dropped, so each frame result is computed from a single coherent sample.
//
// The PWM counter runs continuously over PWM_PERIOD cycles.  The width used
// for the waveform (active_width) is only reloaded at the end of a period,
// so a pulse_width rewrite never truncates or stretches a pulse in flight.
//
// Ports
//   clk          video clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   frame_end    one-cycle pulse, centroid results are final
//   centroid_x   line centroid column (unsigned, 11 bits)
//   line_valid   centroid valid for this frame
//   line_lost    line not found this frame
//   pwm_out      registered servo PWM
//   pulse_width  commanded pulse width in clk cycles
//   steer_error  signed error, clamped centroid minus IMG_W/2
//   state        0 = TRACK, 1 = HOLD, 2 = SEARCH
//   lost_flag    high while in SEARCH
//   update_pulse one-cycle strobe when pulse_width is rewritten
// ---------------------------------------------------------------------------
module steering_controller #(
  parameter int IMG_W        = 640,
  parameter int PWM_PERIOD   = 500000,
  parameter int PULSE_MIN    = 25000,
  parameter int PULSE_CENTER = 37500,
  parameter int PULSE_MAX    = 50000,
  parameter int GAIN         = 45,
  parameter int MAX_STEP     = 2500,
  parameter int LOST_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_end,
  input  logic [10:0]        centroid_x,
  input  logic               line_valid,
  input  logic               line_lost,
  output logic               pwm_out,
  output logic [19:0]        pulse_width,
  output logic signed [11:0] steer_error,
  output logic [1:0]         state,
  output logic               lost_flag,
  output logic               update_pulse
);

  typedef enum logic [1:0] {
    ST_TRACK  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SEARCH = 2'd2
  } state_t;

  localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);

  localparam logic [10:0]        X_MAX    = 11'(IMG_W - 1);
  localparam logic signed [11:0] X_MID    = 12'(IMG_W / 2);
  localparam logic [19:0]        CENTER_U = 20'(PULSE_CENTER);
  // 22-bit signed arithmetic for saturation and step limiting: wide enough
  // that center + product and target - prev can never wrap.
  localparam logic signed [21:0] CENTER_S = 22'(PULSE_CENTER);
  localparam logic signed [21:0] MIN_S    = 22'(PULSE_MIN);
  localparam logic signed [21:0] MAX_S    = 22'(PULSE_MAX);
  localparam logic signed [21:0] STEP_POS = 22'(MAX_STEP);
  localparam logic signed [21:0] STEP_NEG = -22'(MAX_STEP);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [MISS_W-1:0]  LOST_C   = MISS_W'(LOST_FRAMES);

  // ---------------- stage 1: sample and verdict ----------------
  logic        s1_valid_reg;
  logic [10:0] s1_x_reg;
  logic        s1_good_reg;
  logic        s2_valid_reg;
  logic        s2_good_reg;
  logic        accept;
  logic [10:0] x_clamped;

  assign accept    = frame_end && !s1_valid_reg && !s2_valid_reg;
  assign x_clamped = (centroid_x > X_MAX) ? X_MAX : centroid_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_good_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_x_reg    <= x_clamped;
        s1_good_reg <= line_valid && !line_lost;
      end
    end
  end

  // ---------------- stage 2: error and proportional term ----------------
  logic signed [11:0] err_calc;
  logic signed [19:0] err_ext;
  logic signed [19:0] product_calc;
  logic signed [11:0] steer_error_reg;
  logic signed [19:0] product_reg;

  assign err_calc     = $signed({1'b0, s1_x_reg}) - X_MID;
  assign err_ext      = {{8{err_calc[11]}}, err_calc};
  assign product_calc = err_ext * $signed(20'(GAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg    <= 1'b0;
      s2_good_reg     <= 1'b0;
      steer_error_reg <= '0;
      product_reg     <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_good_reg     <= s1_good_reg;
        steer_error_reg <= err_calc;
        product_reg     <= product_calc;
      end
    end
  end

  // ---------------- stage 3: state machine and pulse width ----------------
  state_t             state_reg, state_next;
  logic [MISS_W-1:0]  miss_reg, miss_next, miss_inc;
  logic [19:0]        pulse_width_reg;
  logic               update_pulse_reg;
  logic               do_update;
  logic signed [21:0] prod_ext, target_raw, target_sat, target_sel;
  logic signed [21:0] prev_s, delta, delta_clip, pw_calc;

  always_comb begin
    state_next = state_reg;
    miss_next  = miss_reg;
    do_update  = 1'b0;
    target_sel = CENTER_S;
    miss_inc   = (miss_reg >= LOST_C) ? miss_reg : miss_reg + MISS_W'(1);

    prod_ext   = {{2{product_reg[19]}}, product_reg};
    target_raw = CENTER_S + prod_ext;
    if (target_raw < MIN_S) begin
      target_sat = MIN_S;
    end else if (target_raw > MAX_S) begin
      target_sat = MAX_S;
    end else begin
      target_sat = target_raw;
    end

    if (s2_valid_reg) begin
      if (s2_good_reg) begin
        state_next = ST_TRACK;
        miss_next  = '0;
        do_update  = 1'b1;
        target_sel = target_sat;
      end else begin
        miss_next = miss_inc;
        // A miss recentres the servo only once the line is declared lost;
        // while holding, the last good command is kept.
        if (state_reg == ST_SEARCH || miss_inc >= LOST_C) begin
          state_next = ST_SEARCH;
          do_update  = 1'b1;
        end else begin
          state_next = ST_HOLD;
        end
      end
    end

    prev_s = $signed({2'b00, pulse_width_reg});
    delta  = target_sel - prev_s;
    if (delta > STEP_POS) begin
      delta_clip = STEP_POS;
    end else if (delta < STEP_NEG) begin
      delta_clip = STEP_NEG;
    end else begin
      delta_clip = delta;
    end
    pw_calc = prev_s + delta_clip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_SEARCH;
      miss_reg         <= '0;
      pulse_width_reg  <= CENTER_U;
      update_pulse_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      miss_reg         <= miss_next;
      update_pulse_reg <= do_update;
      if (do_update) begin
        pulse_width_reg <= 20'(pw_calc);
      end
    end
  end

  // ---------------- PWM generator ----------------
  logic [CNT_W-1:0] counter_reg;
  logic [19:0]      active_width_reg;
  logic             pwm_out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_reg      <= '0;
      active_width_reg <= CENTER_U;
      pwm_out_reg      <= 1'b0;
    end else begin
      pwm_out_reg <= (32'(counter_reg) < 32'(active_width_reg));
      if (counter_reg == CNT_LAST) begin
        counter_reg      <= '0;
        active_width_reg <= pulse_width_reg;
      end else begin
        counter_reg <= counter_reg + CNT_W'(1);
      end
    end
  end

  assign pwm_out      = pwm_out_reg;
  assign pulse_width  = pulse_width_reg;
  assign steer_error  = steer_error_reg;
  assign state        = state_reg;
  assign lost_flag    = (state_reg == ST_SEARCH);
  assign update_pulse = update_pulse_reg;

endmodule

// File: doc/steering_controller.md
STEERING_CONTROLLER -- requirements
Module: steering_controller

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels.
REQ-002 SHALL have parameter PWM_PERIOD, default 500000, servo period in clk cycles (20 ms at 25 MHz).
REQ-003 SHALL have parameters PULSE_MIN, PULSE_CENTER and PULSE_MAX, defaults 25000, 37500 and 50000, pulse-width limits and neutral value in cycles.
REQ-004 SHALL have parameter GAIN, default 45, unsigned proportional gain in cycles per pixel of error.
REQ-005 SHALL have parameter MAX_STEP, default 2500, maximum pulse-width change per accepted frame.
REQ-006 SHALL have parameter LOST_FRAMES, default 8, consecutive missed frames before SEARCH.
REQ-007 clk  input  1  video clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 frame_end  input  1  single-cycle pulse once per frame when centroid results are final.
REQ-010 centroid_x  input  11  line centroid column, unsigned.
REQ-011 line_valid  input  1  centroid is valid for this frame.
REQ-012 line_lost  input  1  line not found this frame.
REQ-013 pwm_out  output  1  servo PWM.
REQ-014 pulse_width  output  20  commanded pulse width, in cycles.
REQ-015 steer_error  output  12  signed error, centroid minus IMG_W/2.
REQ-016 state  output  2  current state: 0 = TRACK, 1 = HOLD, 2 = SEARCH.
REQ-017 lost_flag  output  1  high while in SEARCH.
REQ-018 update_pulse  output  1  one-cycle strobe when pulse_width is rewritten.

Function
REQ-019 SHALL accept frame_end only when the 3-stage pipeline is idle; a frame_end arriving while it is busy SHALL be dropped.
REQ-020 Stage 1 (cycle after an accepted frame_end) SHALL register centroid_x, clamped to IMG_W-1, and the frame verdict.
- verdict = good only when line_valid=1 and line_lost=0.
- both flags high, or line_valid=0, counts as a miss.
REQ-021 Stage 2 SHALL compute steer_error = clamped centroid - IMG_W/2 as signed 12-bit, and product = steer_error*GAIN as signed 20-bit.
REQ-022 Stage 3 SHALL form target and then pulse_width.
- target = PULSE_CENTER + product, saturated to [PULSE_MIN, PULSE_MAX].
- in SEARCH (verdict = miss), target = PULSE_CENTER.
- pulse_width = prev + clip(target - prev, -MAX_STEP, +MAX_STEP).
- update_pulse is high for that one cycle.
- total latency, frame_end to update_pulse: 3 cycles.
REQ-023 In HOLD, pulse_width SHALL stay unchanged and update_pulse SHALL stay low.
REQ-024 State transitions SHALL be evaluated in stage 3.
- any state, good verdict -> TRACK; miss count cleared.
- TRACK, miss -> HOLD; miss count = 1.
- HOLD, miss -> miss count +1; on reaching LOST_FRAMES -> SEARCH.
- SEARCH, miss -> stay in SEARCH; miss count saturates.
REQ-025 lost_flag SHALL equal (state == SEARCH).
REQ-026 The PWM counter SHALL count 0..PWM_PERIOD-1 and wrap to 0.
REQ-027 pwm_out SHALL be registered and high while counter < active_width.
REQ-028 active_width SHALL load from pulse_width only when counter = PWM_PERIOD-1, so each period is glitch-free and a mid-period update takes effect next period.
REQ-029 Saturation and step clipping SHALL use at least 21-bit signed intermediates; no wrap-around is permitted.

Reset
REQ-030 On rst, the following SHALL take these values on the next clock edge, regardless of pipeline or PWM phase:
- pwm_out=0, counter=0
- pulse_width = active_width = PULSE_CENTER
- steer_error=0, state=SEARCH, lost_flag=1
- update_pulse=0, miss count=0
- pipeline emptied; an in-flight frame is discarded.
REQ-031 The first PWM period after reset SHALL start at counter=0 one cycle after rst deasserts.

Verification
REQ-032 Reset idle: no frame_end -> pwm_out high exactly 37500 of every 500000 cycles; state=2; lost_flag=1.
REQ-033 Centred line: frame_end, line_valid=1, centroid 320 -> update_pulse exactly 3 cycles later; steer_error=0; pulse_width=37500; state=0; lost_flag=0.
REQ-034 Rate limit and clamp: from 37500, five good frames with centroid 639 (product 14355, target clamped to 50000) -> pulse_width 40000, 42500, 45000, 47500, 50000.
- next period's pwm_out high time = 50000.
- centroid 2000 behaves as 639.
REQ-035 Loss sequence: in TRACK at 45000, seven miss frames -> state=1 and pulse_width stays 45000; eighth miss -> state=2, lost_flag=1, pulse_width 42500 (toward 37500).
- a good frame then -> state=0.
REQ-036 Edge cases:
- line_valid=1 with line_lost=1 -> treated as a miss.
- second frame_end 1 cycle after the first -> ignored.
- pulse_width update mid-period -> current period's high time unchanged.
- rst mid-high-pulse -> pwm_out=0 on the next cycle.
